// File: rtl/baud_tick_generator_pkg.sv
`default_nettype none
// ============================================================================
// baud_tick_generator_pkg: shared constants and reset-divisor helper. Rev 1.0
// ============================================================================
package baud_tick_generator_pkg;

    localparam int unsigned OVERSAMPLING_8  = 8;
    localparam int unsigned OVERSAMPLING_16 = 16;

    // Rounded fixed-point clk cycles per rx tick, FRAC_BITS fractional bits.
    function automatic longint unsigned calc_default_divisor(
        input longint unsigned clock_rate,
        input longint unsigned baud_rate,
        input longint unsigned oversampling,
        input longint unsigned frac_bits
    );
        longint unsigned num;
        longint unsigned den;
        num = clock_rate << frac_bits;
        den = baud_rate * oversampling;
        return (num + (den >> 1)) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_frac_divider.sv
`default_nettype none
// ============================================================================
// baud_frac_divider: fractional I.F down-counter with tick phase. Rev 1.0
// ============================================================================
module baud_frac_divider
    import baud_tick_generator_pkg::*;
#(
    parameter int unsigned                       INT_BITS        = 16,
    parameter int unsigned                       FRAC_BITS       = 8,
    parameter int unsigned                       PHASES          = OVERSAMPLING_16,
    parameter logic [INT_BITS+FRAC_BITS-1:0]     DEFAULT_DIVISOR = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 run_i,
    input  logic                                 resync_i,
    input  logic [INT_BITS+FRAC_BITS-1:0]        new_div_i,
    input  logic                                 new_valid_i,
    output logic                                 adopt_o,
    output logic                                 tick_o,
    output logic [$clog2(PHASES)-1:0]            phase_o
);

    localparam int unsigned DIV_W   = INT_BITS + FRAC_BITS;
    localparam int unsigned PHASE_W = $clog2(PHASES);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

    logic [DIV_W-1:0]     div_q, div_d, div_use;
    logic [INT_BITS-1:0]  cnt_q, cnt_d, int_use;
    logic [FRAC_BITS-1:0] acc_q, acc_d, frac_use, acc_sum;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 carry;
    logic                 tick;

    always_comb begin
        tick     = run_i && !resync_i && (cnt_q == '0);
        adopt_o  = new_valid_i && (!run_i || tick);
        // A pending divisor takes effect in the very reload that adopts it.
        div_use  = adopt_o ? new_div_i : div_q;
        int_use  = div_use[DIV_W-1:FRAC_BITS];
        frac_use = div_use[FRAC_BITS-1:0];
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_use};

        div_d   = div_use;
        cnt_d   = cnt_q - INT_BITS'(1);
        acc_d   = acc_q;
        phase_d = phase_q;

        if (!run_i) begin
            cnt_d   = int_use - INT_BITS'(1);
            acc_d   = '0;
            phase_d = '0;
        end else if (resync_i) begin
            cnt_d   = (int_use >> 1) - INT_BITS'(1);
            acc_d   = '0;
            phase_d = '0;
        end else if (tick) begin
            cnt_d   = int_use - INT_BITS'(1) + INT_BITS'(carry);
            acc_d   = acc_sum;
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= DEFAULT_DIVISOR;
            cnt_q   <= '0;
            acc_q   <= '0;
            phase_q <= '0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end

    assign tick_o  = tick;
    assign phase_o = phase_q;

endmodule
`default_nettype wire

// File: rtl/baud_tick_generator.sv
`default_nettype none
// ============================================================================
// baud_tick_generator: rx oversampling and tx bit-rate tick enables. Rev 1.0
// ============================================================================
module baud_tick_generator
    import baud_tick_generator_pkg::*;
#(
    parameter int unsigned CLOCK_RATE   = 100_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned INT_BITS     = 16,
    parameter int unsigned FRAC_BITS    = 8
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic                              enable,
    input  logic                              cfgValid,
    output logic                              cfgReady,
    input  logic [INT_BITS+FRAC_BITS-1:0]     cfgDivisor,
    output logic                              cfgError,
    input  logic                              rxResync,
    output logic                              rxTick,
    output logic [$clog2(OVERSAMPLING)-1:0]   rxPhase,
    output logic                              txTick
);

    localparam int unsigned DIV_W   = INT_BITS + FRAC_BITS;
    localparam int unsigned PHASE_W = $clog2(OVERSAMPLING);
    localparam bit          OVS_LEGAL = (OVERSAMPLING == OVERSAMPLING_8) ||
                                        (OVERSAMPLING == OVERSAMPLING_16);
    localparam int unsigned PHASES  = OVS_LEGAL ? OVERSAMPLING : OVERSAMPLING_16;
    localparam logic [DIV_W-1:0] DEFAULT_DIVISOR = DIV_W'(calc_default_divisor(
        64'(CLOCK_RATE), 64'(BAUD_RATE), 64'(OVERSAMPLING), 64'(FRAC_BITS)));

    logic [DIV_W-1:0]   shadow_q, shadow_d;
    logic               pend_rx_q, pend_rx_d;
    logic               pend_tx_q, pend_tx_d;
    logic               err_q, err_d;
    logic               en_q;
    logic               run;
    logic               accept;
    logic               illegal;
    logic               rx_adopt, tx_adopt;
    logic               tx_tick;
    logic [PHASE_W-1:0] tx_phase;

    // Dividers start one cycle after enable is sampled so the first tick
    // lands exactly I cycles after enable rises, and never during reset.
    assign run      = enable && en_q;
    assign cfgReady = !pend_rx_q && !pend_tx_q;
    assign accept   = cfgValid && cfgReady;
    assign illegal  = cfgDivisor[DIV_W-1:FRAC_BITS] < INT_BITS'(2);

    always_comb begin
        shadow_d  = shadow_q;
        pend_rx_d = pend_rx_q && !rx_adopt;
        pend_tx_d = pend_tx_q && !tx_adopt;
        err_d     = accept && illegal;
        if (accept && !illegal) begin
            shadow_d  = cfgDivisor;
            pend_rx_d = 1'b1;
            pend_tx_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shadow_q  <= DEFAULT_DIVISOR;
            pend_rx_q <= 1'b0;
            pend_tx_q <= 1'b0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pend_rx_q <= pend_rx_d;
            pend_tx_q <= pend_tx_d;
            err_q     <= err_d;
            en_q      <= enable;
        end
    end

    baud_frac_divider #(
        .INT_BITS        (INT_BITS),
        .FRAC_BITS       (FRAC_BITS),
        .PHASES          (PHASES),
        .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
    ) u_rx_div (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .run_i       (run),
        .resync_i    (rxResync),
        .new_div_i   (shadow_q),
        .new_valid_i (pend_rx_q),
        .adopt_o     (rx_adopt),
        .tick_o      (rxTick),
        .phase_o     (rxPhase)
    );

    baud_frac_divider #(
        .INT_BITS        (INT_BITS),
        .FRAC_BITS       (FRAC_BITS),
        .PHASES          (PHASES),
        .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
    ) u_tx_div (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .run_i       (run),
        .resync_i    (1'b0),
        .new_div_i   (shadow_q),
        .new_valid_i (pend_tx_q),
        .adopt_o     (tx_adopt),
        .tick_o      (tx_tick),
        .phase_o     (tx_phase)
    );

    assign txTick   = tx_tick && (tx_phase == PHASE_W'(OVERSAMPLING - 1));
    assign cfgError = err_q;

endmodule
`default_nettype wire
